// File: rtl/perf_seq_pkg.sv
// Shared types and constants for the performance counter request sequencer.
package perf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RD0   = 3'd2,
    RD1   = 3'd3,
    RD2   = 3'd4,
    RD3   = 3'd5,
    OUT   = 3'd6
  } state_t;

  // Counter slave word map: each section owns a 4-word window.
  localparam int unsigned SEC_STRIDE = 4;
  localparam int unsigned STOP_OFS   = 0;  // write 0 to stop, write 1 at section 0 = global clear
  localparam int unsigned GO_OFS     = 1;
  localparam int unsigned EVT_OFS    = 2;
  localparam int unsigned TLO_OFS    = 0;  // read side of the same window
  localparam int unsigned THI_OFS    = 1;

  typedef struct packed {
    logic [2:0]  section;
    logic [63:0] time_cnt;
    logic [31:0] events;
  } snap_rec_t;

  function automatic logic [4:0] sec_addr(input logic [2:0] sec, input int unsigned ofs);
    return 5'(sec * SEC_STRIDE + ofs);
  endfunction

endpackage

// File: rtl/perf_seq_pick.sv
// Lowest-set-bit priority encoder: flags any request and returns its index.
module perf_seq_pick #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [W-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan upward; the first set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/perf_counter_sequencer.sv
// Serializes go/stop/clear/snapshot requests into performance counter slave
// transfers and returns each snapshot as one valid/ready record.
module perf_counter_sequencer
  import perf_seq_pkg::*;
#(
  parameter int unsigned NUM_SECTIONS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SECTIONS-1:0] go_req,
  input  logic [NUM_SECTIONS-1:0] stop_req,
  input  logic [NUM_SECTIONS-1:0] snap_req,
  input  logic                    clear_req,
  output logic [4:0]              pc_address,
  output logic                    pc_begintransfer,
  output logic                    pc_write,
  output logic [31:0]             pc_writedata,
  input  logic [31:0]             pc_readdata,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [2:0]              snap_section,
  output logic [63:0]             snap_time,
  output logic [31:0]             snap_events,
  output logic                    busy,
  output logic                    overrun
);

  state_t state_q, state_d;

  logic [NUM_SECTIONS-1:0] go_pend, stop_pend, snap_pend;
  logic [NUM_SECTIONS-1:0] go_pend_d, stop_pend_d, snap_pend_d;
  logic [NUM_SECTIONS-1:0] go_gnt, stop_gnt, snap_gnt;
  logic [NUM_SECTIONS-1:0] go_clr, stop_clr;
  logic                    clr_pend, clr_pend_d, clr_grant;
  logic                    overrun_d, busy_d, hit;

  logic                    go_v, stop_v, snap_v;
  logic [2:0]              go_idx, stop_idx, snap_idx;

  logic [2:0]              sec_q, sec_d;
  logic [31:0]             lo_q, hi_q;
  snap_rec_t               rec_q;

  logic [4:0]              addr_d;
  logic                    bt_d, wr_d, valid_d, load_rec;
  logic [31:0]             wdata_d;

  perf_seq_pick #(.W(NUM_SECTIONS), .IDX_W(3)) u_pick_stop (
    .req   (stop_pend),
    .valid (stop_v),
    .idx   (stop_idx)
  );

  perf_seq_pick #(.W(NUM_SECTIONS), .IDX_W(3)) u_pick_go (
    .req   (go_pend),
    .valid (go_v),
    .idx   (go_idx)
  );

  perf_seq_pick #(.W(NUM_SECTIONS), .IDX_W(3)) u_pick_snap (
    .req   (snap_pend),
    .valid (snap_v),
    .idx   (snap_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, grant selection and next values of the registered slave/record outputs.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    addr_d    = '0;
    bt_d      = 1'b0;
    wr_d      = 1'b0;
    wdata_d   = '0;
    valid_d   = 1'b0;
    load_rec  = 1'b0;
    clr_grant = 1'b0;
    go_gnt    = '0;
    stop_gnt  = '0;
    snap_gnt  = '0;
    case (state_q)
      IDLE: begin
        if (clr_pend) begin
          clr_grant = 1'b1;
          state_d   = WRITE;
          addr_d    = sec_addr(3'd0, STOP_OFS);
          bt_d      = 1'b1;
          wr_d      = 1'b1;
          wdata_d   = 32'd1;
        end else if (stop_v) begin
          stop_gnt  = NUM_SECTIONS'(1) << stop_idx;
          state_d   = WRITE;
          addr_d    = sec_addr(stop_idx, STOP_OFS);
          bt_d      = 1'b1;
          wr_d      = 1'b1;
        end else if (go_v) begin
          go_gnt    = NUM_SECTIONS'(1) << go_idx;
          state_d   = WRITE;
          addr_d    = sec_addr(go_idx, GO_OFS);
          bt_d      = 1'b1;
          wr_d      = 1'b1;
        end else if (snap_v) begin
          snap_gnt  = NUM_SECTIONS'(1) << snap_idx;
          sec_d     = snap_idx;
          state_d   = RD0;
          addr_d    = sec_addr(snap_idx, TLO_OFS);
          bt_d      = 1'b1;
        end
      end
      WRITE: state_d = IDLE;
      RD0: begin
        state_d = RD1;
        addr_d  = sec_addr(sec_q, THI_OFS);
        bt_d    = 1'b1;
      end
      RD1: begin
        state_d = RD2;
        addr_d  = sec_addr(sec_q, EVT_OFS);
        bt_d    = 1'b1;
      end
      RD2: begin
        // Address held one more cycle so the registered read of the event word lands in RD3.
        state_d = RD3;
        addr_d  = sec_addr(sec_q, EVT_OFS);
      end
      RD3: begin
        state_d  = OUT;
        valid_d  = 1'b1;
        load_rec = 1'b1;
      end
      OUT: begin
        if (snap_ready) state_d = IDLE;
        else            valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending-bit update: granted bits drop, new pulses set; a pulse into an already-set,
  // not-just-granted bit is an overrun. A clear grant wipes go/stop but keeps snapshots.
  always_comb begin
    stop_clr    = clr_grant ? '1 : stop_gnt;
    go_clr      = clr_grant ? '1 : go_gnt;
    stop_pend_d = (stop_pend & ~stop_clr) | stop_req;
    go_pend_d   = (go_pend & ~go_clr) | go_req;
    snap_pend_d = (snap_pend & ~snap_gnt) | snap_req;
    clr_pend_d  = (clr_pend & ~clr_grant) | clear_req;
    hit         = (|(stop_req & stop_pend & ~stop_clr)) |
                  (|(go_req & go_pend & ~go_clr)) |
                  (|(snap_req & snap_pend & ~snap_gnt)) |
                  (clear_req & clr_pend & ~clr_grant);
    overrun_d   = (overrun & ~clr_grant) | hit;
    busy_d      = (state_d != IDLE) | (|stop_pend_d) | (|go_pend_d) |
                  (|snap_pend_d) | clr_pend_d;
  end

  // Pending registers, status flags and registered slave-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_pend          <= '0;
      stop_pend        <= '0;
      snap_pend        <= '0;
      clr_pend         <= 1'b0;
      overrun          <= 1'b0;
      busy             <= 1'b0;
      sec_q            <= '0;
      pc_address       <= '0;
      pc_begintransfer <= 1'b0;
      pc_write         <= 1'b0;
      pc_writedata     <= '0;
    end else begin
      go_pend          <= go_pend_d;
      stop_pend        <= stop_pend_d;
      snap_pend        <= snap_pend_d;
      clr_pend         <= clr_pend_d;
      overrun          <= overrun_d;
      busy             <= busy_d;
      sec_q            <= sec_d;
      pc_address       <= addr_d;
      pc_begintransfer <= bt_d;
      pc_write         <= wr_d;
      pc_writedata     <= wdata_d;
    end
  end

  // Snapshot capture; the record is only published once all three words are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q       <= '0;
      hi_q       <= '0;
      rec_q      <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (state_q == RD1) lo_q <= pc_readdata;
      if (state_q == RD2) hi_q <= pc_readdata;
      if (load_rec) begin
        rec_q.section  <= sec_q;
        rec_q.time_cnt <= {hi_q, lo_q};
        rec_q.events   <= pc_readdata;
      end
      snap_valid <= valid_d;
    end
  end

  assign snap_section = rec_q.section;
  assign snap_time    = rec_q.time_cnt;
  assign snap_events  = rec_q.events;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench for perf_counter_sequencer: stimulus pushes expected slave writes
// and snapshot records; a negedge monitor pops and compares as the DUT presents them.
module tb_perf_counter_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  go_req = '0, stop_req = '0, snap_req = '0;
  logic        clear_req = 1'b0;
  logic [4:0]  pc_address;
  logic        pc_begintransfer, pc_write;
  logic [31:0] pc_writedata;
  logic [31:0] pc_readdata = '0;
  logic        snap_valid;
  logic        snap_ready = 1'b0;
  logic [2:0]  snap_section;
  logic [63:0] snap_time;
  logic [31:0] snap_events;
  logic        busy, overrun;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_snap;
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  sec;
    logic [63:0] tm;
    logic [31:0] ev;
  } exp_t;

  exp_t sbq[$];

  perf_counter_sequencer #(.NUM_SECTIONS(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .go_req           (go_req),
    .stop_req         (stop_req),
    .snap_req         (snap_req),
    .clear_req        (clear_req),
    .pc_address       (pc_address),
    .pc_begintransfer (pc_begintransfer),
    .pc_write         (pc_write),
    .pc_writedata     (pc_writedata),
    .pc_readdata      (pc_readdata),
    .snap_valid       (snap_valid),
    .snap_ready       (snap_ready),
    .snap_section     (snap_section),
    .snap_time        (snap_time),
    .snap_events      (snap_events),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] slave_rd(input logic [4:0] a);
    case (a)
      5'd12:   return 32'h11;
      5'd13:   return 32'h22;
      5'd14:   return 32'h33;
      default: return 32'h1000_0000 | {27'd0, a};
    endcase
  endfunction

  // Registered slave model: data one cycle after the address.
  always @(posedge clk) pc_readdata <= slave_rd(pc_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e = '{is_snap: 1'b0, cyc: c, addr: a, data: d, sec: 3'd0, tm: 64'd0, ev: 32'd0};
    sbq.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic [2:0] s, input logic [63:0] t,
                           input logic [31:0] ev);
    exp_t e;
    e = '{is_snap: 1'b1, cyc: c, addr: 5'd0, data: 32'd0, sec: s, tm: t, ev: ev};
    sbq.push_back(e);
  endtask

  // Advance to cycle k, 2 time units after its rising edge (input drive point).
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {pc_address, pc_begintransfer, pc_write, snap_valid, snap_section,
                        busy, overrun}, 64'd0);
    chk({tag, "_wdata"}, pc_writedata, 64'd0);
    chk({tag, "_time"}, snap_time, 64'd0);
    chk({tag, "_events"}, snap_events, 64'd0);
  endtask

  // Monitor: each write strobe and each accepted record consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (pc_write) begin
        if (sbq.size() == 0 || sbq[0].is_snap) begin
          n_chk++;
          n_fail++;
          $display("FAIL wr_unexpected: got write addr %0d data %0h at cycle %0d, required none",
                   pc_address, pc_writedata, cyc);
        end else begin
          e = sbq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
          chk("wr_addr", 64'(pc_address), 64'(e.addr));
          chk("wr_data", 64'(pc_writedata), 64'(e.data));
          chk("wr_begin", 64'(pc_begintransfer), 64'd1);
        end
      end
      if (snap_valid && snap_ready) begin
        if (sbq.size() == 0 || !sbq[0].is_snap) begin
          n_chk++;
          n_fail++;
          $display("FAIL snap_unexpected: got record section %0d at cycle %0d, required none",
                   snap_section, cyc);
        end else begin
          e = sbq.pop_front();
          chk("snap_cycle", 64'(cyc), 64'(e.cyc));
          chk("snap_section", 64'(snap_section), 64'(e.sec));
          chk("snap_time", snap_time, e.tm);
          chk("snap_events", 64'(snap_events), 64'(e.ev));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, during and after reset.
    go_to(2);
    @(negedge clk);
    chk_zero("rst_held");
    go_to(3);
    reset = 1'b0;
    go_to(4);
    @(negedge clk);
    chk_zero("rst_rel");

    // Single go then stop on section 0.
    go_to(10); go_req = 8'h01; push_wr(12, 5'd1, 32'd0);
    go_to(11); go_req = '0;
    go_to(12); @(negedge clk);
    chk("go0_busy", 64'(busy), 64'd1);
    go_to(30); stop_req = 8'h01; push_wr(32, 5'd0, 32'd0);
    go_to(31); stop_req = '0;

    // Simultaneous go/stop: stop first, then go in index order, 2-cycle spacing.
    go_to(40); go_req = 8'h06; stop_req = 8'h02;
    push_wr(42, 5'd4, 32'd0);
    push_wr(44, 5'd5, 32'd0);
    push_wr(46, 5'd9, 32'd0);
    go_to(41); go_req = '0; stop_req = '0;

    // Snapshot of section 3 with back-pressure.
    go_to(60); snap_req = 8'h08;
    push_snap(71, 3'd3, 64'h0000_0022_0000_0011, 32'h33);
    go_to(61); snap_req = '0;
    for (int k = 0; k < 4; k++) begin
      go_to(62 + k);
      @(negedge clk);
      chk("rd_addr", 64'(pc_address), 64'(12 + ((k > 2) ? 2 : k)));
      chk("rd_begin", 64'(pc_begintransfer), (k < 3) ? 64'd1 : 64'd0);
    end
    for (int k = 66; k <= 70; k++) begin
      go_to(k);
      @(negedge clk);
      chk("snap_hold_valid", 64'(snap_valid), 64'd1);
      chk("snap_hold_sec", 64'(snap_section), 64'd3);
    end
    go_to(71); snap_ready = 1'b1;
    go_to(72); snap_ready = 1'b0;
    @(negedge clk);
    chk("snap_released", 64'(snap_valid), 64'd0);
    chk("snap_idle_busy", 64'(busy), 64'd0);

    // Duplicate go while a record is waiting in OUT, then a clear.
    go_to(80); snap_req = 8'h02;
    push_snap(92, 3'd1, 64'h1000_0005_1000_0004, 32'h1000_0006);
    push_wr(94, 5'd9, 32'd0);
    go_to(81); snap_req = '0;
    go_to(87); go_req = 8'h04;
    go_to(88); go_req = '0;
    go_to(89); go_req = 8'h04;
    go_to(90); go_req = '0;
    @(negedge clk);
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_busy", 64'(busy), 64'd1);
    go_to(92); snap_ready = 1'b1;
    go_to(93); snap_ready = 1'b0;
    go_to(96); clear_req = 1'b1; push_wr(98, 5'd0, 32'd1);
    go_to(97); clear_req = 1'b0;
    @(negedge clk);
    chk("ovr_before_clear", 64'(overrun), 64'd1);
    go_to(98);
    @(negedge clk);
    chk("ovr_cleared", 64'(overrun), 64'd0);

    // Reset in the middle of a snapshot read.
    go_to(110); snap_req = 8'h20;
    go_to(111); snap_req = '0;
    go_to(114);
    @(negedge clk);
    chk("rd2_addr", 64'(pc_address), 64'd22);
    chk("rd2_begin", 64'(pc_begintransfer), 64'd1);
    #1 reset = 1'b1;
    #1 chk_zero("rst_async");
    go_to(116); reset = 1'b0;
    for (int k = 116; k < 128; k++) begin
      go_to(k);
      @(negedge clk);
      chk("no_partial_snap", 64'(snap_valid), 64'd0);
    end
    chk("post_rst_busy", 64'(busy), 64'd0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
